wb_ps2_fifo: RTL

//  Wishbone slave for a PS/2 byte engine, with a parametrised RX FIFO, a TX command queue and a maskable interrupt.
//  The host can queue multi-byte mouse/keyboard init sequences without polling tx_busy between bytes.

---
 rtl/wb_ps2_fifo_pkg.sv | 30 +++
 rtl/wb_ps2_fifo_sync_fifo.sv | 60 ++++++
 rtl/wb_ps2_fifo.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/wb_ps2_fifo_pkg.sv
// Shared definitions for the Wishbone PS/2 FIFO block: register decode,
// STATUS/CTRL bit positions and the TX sequencer states.
package ps2_pkg;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_RXDATA = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;

    localparam int ST_TX_BUSY   = 0;
    localparam int ST_TX_FULL   = 1;
    localparam int ST_RX_NEMPTY = 2;
    localparam int ST_RX_OVF    = 3;
    localparam int ST_RX_ERR    = 4;
    localparam int ST_TX_OVF    = 5;
    localparam int ST_IRQ       = 6;

    localparam int CTRL_RX_IE     = 0;
    localparam int CTRL_TXDONE_IE = 1;
    localparam int CTRL_ERR_IE    = 2;
    localparam int CTRL_FLUSH     = 3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LAUNCH,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/wb_ps2_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module ps2_sync_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush && reset) begin
            mem[wr_ptr] <= din;
        end
    end

    // Flush shares the reset path so it always beats a same-cycle push.
    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/wb_ps2_fifo.sv
// Wishbone slave wrapping a PS/2 byte engine with an RX FIFO, a TX command
// queue feeding a small launch sequencer, and a maskable level interrupt.
module wb_ps2_fifo
    import ps2_pkg::*;
#(
    parameter int RX_AW = 4,
    parameter int TX_AW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic [7:0]  eng_rx_data,
    input  logic        eng_rx_valid,
    input  logic        eng_rx_err,
    output logic [7:0]  eng_tx_data,
    output logic        eng_tx_start,
    input  logic        eng_tx_busy,
    output logic        irq
);

    logic        ack_q;
    logic        access;
    logic        wr;
    logic        rd;
    logic [2:0]  reg_sel;
    logic [31:0] read_mux;
    logic [31:0] status_word;

    logic        rx_ie;
    logic        txdone_ie;
    logic        err_ie;
    logic [7:0]  rx_thresh;
    logic        rx_ovf;
    logic        rx_err;
    logic        tx_ovf;
    logic        txdone_flag;
    logic        flush;

    logic        rx_push;
    logic        rx_pop;
    logic [7:0]  rx_dout;
    logic        rx_full;
    logic        rx_empty;
    logic [RX_AW:0] rx_level;
    logic [7:0]  rx_level_ext;
    logic [7:0]  thresh_eff;

    logic        tx_push;
    logic        tx_pop;
    logic [7:0]  tx_dout;
    logic        tx_full;
    logic        tx_empty;
    logic [TX_AW:0] tx_level;
    logic        tx_done;
    logic        tx_busy_any;
    logic        irq_d;
    tx_state_t   state;

    logic        unused_bits;

    assign access   = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr       = access & wb_we_i & wb_sel_i[0];
    assign rd       = access & ~wb_we_i;
    assign reg_sel  = wb_adr_i[4:2];
    assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_q;

    assign flush   = wr && (reg_sel == REG_CTRL) && wb_dat_i[CTRL_FLUSH];
    assign rx_push = eng_rx_valid & ~eng_rx_err;
    assign rx_pop  = rd && (reg_sel == REG_RXDATA) && !rx_empty;
    assign tx_push = wr && (reg_sel == REG_TXDATA);
    assign tx_pop  = (state == TX_IDLE) && !tx_empty && !flush;
    assign tx_done = (state == TX_WAIT_DONE) && !eng_tx_busy;

    assign tx_busy_any  = (state != TX_IDLE) | eng_tx_busy;
    assign rx_level_ext = 8'(rx_level);
    assign thresh_eff   = (rx_thresh == 8'd0) ? 8'd1 : rx_thresh;
    assign irq_d = (rx_ie & (rx_level_ext >= thresh_eff))
                 | (txdone_ie & txdone_flag)
                 | (err_ie & (rx_ovf | rx_err | tx_ovf));

    assign status_word = {16'h0, rx_level_ext, 1'b0, irq, tx_ovf, rx_err,
                          rx_ovf, ~rx_empty, tx_full, tx_busy_any};

    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_sel_i[3:1],
                           wb_dat_i[31:16], tx_level};

    ps2_sync_fifo #(.W(8), .AW(RX_AW)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (flush),
        .din   (eng_rx_data),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    ps2_sync_fifo #(.W(8), .AW(TX_AW)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (flush),
        .din   (wb_dat_i[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    always_comb begin
        read_mux = '0;
        case (reg_sel)
            REG_STATUS: read_mux = status_word;
            REG_RXDATA: if (!rx_empty) read_mux = {23'h0, 1'b1, rx_dout};
            REG_CTRL:   read_mux = {16'h0, rx_thresh, 5'h0, err_ie, txdone_ie, rx_ie};
            default:    read_mux = '0;
        endcase
    end

    // Bus register file; every side effect keys off the single access cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ack_q       <= 1'b0;
            wb_dat_o    <= '0;
            rx_ie       <= 1'b0;
            txdone_ie   <= 1'b0;
            err_ie      <= 1'b0;
            rx_thresh   <= '0;
            rx_ovf      <= 1'b0;
            rx_err      <= 1'b0;
            tx_ovf      <= 1'b0;
            txdone_flag <= 1'b0;
            irq         <= 1'b0;
        end else begin
            ack_q    <= access;
            wb_dat_o <= rd ? read_mux : 32'h0;
            irq      <= irq_d;

            if (wr && reg_sel == REG_CTRL) begin
                rx_ie     <= wb_dat_i[CTRL_RX_IE];
                txdone_ie <= wb_dat_i[CTRL_TXDONE_IE];
                err_ie    <= wb_dat_i[CTRL_ERR_IE];
                rx_thresh <= wb_dat_i[15:8];
            end

            if (wr && reg_sel == REG_STATUS) begin
                rx_ovf <= (rx_ovf & ~wb_dat_i[ST_RX_OVF]) | (rx_push & rx_full & ~rx_pop & ~flush);
                rx_err <= (rx_err & ~wb_dat_i[ST_RX_ERR]) | (eng_rx_valid & eng_rx_err);
                tx_ovf <= tx_ovf & ~wb_dat_i[ST_TX_OVF];
            end else begin
                rx_ovf <= rx_ovf | (rx_push & rx_full & ~rx_pop & ~flush);
                rx_err <= rx_err | (eng_rx_valid & eng_rx_err);
                tx_ovf <= tx_ovf | (tx_push & tx_full & ~tx_pop);
            end

            if (flush || tx_push) begin
                txdone_flag <= 1'b0;
            end else if (tx_done && tx_empty) begin
                txdone_flag <= 1'b1;
            end
        end
    end

    // TX sequencer: flush empties the queue but never aborts the byte in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= TX_IDLE;
            eng_tx_start <= 1'b0;
            eng_tx_data  <= '0;
        end else begin
            eng_tx_start <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        eng_tx_data  <= tx_dout;
                        eng_tx_start <= 1'b1;
                        state        <= TX_LAUNCH;
                    end
                end
                TX_LAUNCH:    state <= TX_WAIT_BUSY;
                TX_WAIT_BUSY: if (eng_tx_busy) state <= TX_WAIT_DONE;
                TX_WAIT_DONE: if (!eng_tx_busy) state <= TX_IDLE;
                default:      state <= TX_IDLE;
            endcase
        end
    end

endmodule
